// File: rtl/sha256.sv
// rtl/sha256.sv - iterative single-block SHA-256 compression, one round per clock
module sha256 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [639:0] data,
    output logic         ready,
    output logic [255:0] hash
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      state;
    logic [5:0]  round;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w [16];

    logic [31:0] ch, maj, t1, t2, a_next, e_next, w_next;
    logic        unused_reserved;

    assign unused_reserved = ^data[639:512];

    // w[0] always holds W[round]; w_next is W[round+16], shifted in at the top
    always_comb begin
        ch     = (e & f) ^ (~e & g);
        maj    = (a & b) ^ (a & c) ^ (b & c);
        t1     = h + big_sigma1(e) + ch + K[round] + w[0];
        t2     = big_sigma0(a) + maj;
        a_next = t1 + t2;
        e_next = d + t1;
        w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b0;
            hash  <= '0;
            round <= '0;
            a <= '0; b <= '0; c <= '0; d <= '0;
            e <= '0; f <= '0; g <= '0; h <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) w[i] <= data[511 - 32*i -: 32];
                        a <= IV[255:224]; b <= IV[223:192];
                        c <= IV[191:160]; d <= IV[159:128];
                        e <= IV[127:96];  f <= IV[95:64];
                        g <= IV[63:32];   h <= IV[31:0];
                        round <= '0;
                        ready <= 1'b0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    h <= g; g <= f; f <= e; e <= e_next;
                    d <= c; c <= b; b <= a; a <= a_next;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_next;
                    round <= round + 6'd1;
                    if (round == 6'd63) begin
                        // Digest uses the post-round-63 register values
                        hash <= {IV[255:224] + a_next, IV[223:192] + a,
                                 IV[191:160] + b,      IV[159:128] + c,
                                 IV[127:96]  + e_next, IV[95:64]   + e,
                                 IV[63:32]   + f,      IV[31:0]    + g};
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256.sv
// tb/tb_sha256.sv - scoreboard bench for sha256 against FIPS 180-4 vectors
module tb_sha256;

    localparam logic [511:0] ABC_MSG   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_MSG = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_DIG   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    typedef struct {
        logic [255:0] digest;
        int           start_cycle;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [639:0] data;
    logic         ready;
    logic [255:0] hash;

    exp_t sb[$];
    int   cycle      = 0;
    int   done_count = 0;
    int   n_checks   = 0;
    int   n_pass     = 0;
    logic ready_prev = 1'b0;

    sha256 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .ready (ready),
        .hash  (hash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [639:0] blk, input logic [255:0] dig, input string name);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        data  = blk;
        e.digest      = dig;
        e.start_cycle = cycle + 1;
        e.name        = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        data  = {$urandom, $urandom, {18{$urandom}}};
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("completion_count", done_count, target);
    endtask

    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_digest"}, hash, e.digest);
                check({e.name, "_latency"}, cycle - e.start_cycle, 64);
                done_count++;
            end
        end
        ready_prev = ready;
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_hash", hash, 0);
        reset = 1'b0;

        send({128'h0, ABC_MSG}, ABC_DIG, "abc");
        wait_done(1);
        send({128'h0, EMPTY_MSG}, EMPTY_DIG, "empty");
        wait_done(2);
        send({{128{1'b1}}, ABC_MSG}, ABC_DIG, "reserved");
        wait_done(3);

        // second request mid-computation must be dropped
        send({128'h0, ABC_MSG}, ABC_DIG, "busy");
        repeat (29) @(negedge clk);
        start = 1'b1;
        data  = {128'h0, EMPTY_MSG};
        @(negedge clk);
        start = 1'b0;
        wait_done(4);
        repeat (70) @(negedge clk);
        check("busy_hold_ready", ready, 1);
        check("busy_hold_hash", hash, ABC_DIG);
        check("busy_no_extra", done_count, 4);

        send({128'h0, EMPTY_MSG}, EMPTY_DIG, "b2b");
        check("b2b_ready_drop", ready, 0);
        check("b2b_hash_hold", hash, ABC_DIG);
        wait_done(5);

        send({128'h0, ABC_MSG}, ABC_DIG, "aborted");
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("async_reset_ready", ready, 0);
        check("async_reset_hash", hash, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        check("post_abort_ready", ready, 0);
        check("post_abort_hash", hash, 0);
        check("post_abort_count", done_count, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sha256.md
Name: sha256

Overview:
Iterative single-block SHA-256 compression engine for the mining datapath. It accepts one pre-padded 512-bit message block on a `start` pulse and runs the 64 rounds, one round per clock. It then adds the standard SHA-256 initial hash value and presents the 256-bit digest with a `ready` flag. Padding and multi-block chaining are the caller's job. The 640-bit data port is sized for an 80-byte header; only the low 512 bits are compressed.

Parameters:
None. Round constants K[0..63] and the initial hash H0..H7 are fixed FIPS 180-4 values, held in internal ROM or case logic.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; samples `data` on the same edge.
- data  input  640  [511:0] is the padded message block, big-endian: W0 = data[511:480] … W15 = data[31:0]. [639:512] is reserved and ignored.
- ready  output  1  digest valid; level signal.
- hash  output  256  digest, big-endian: H0 in hash[255:224] … H7 in hash[31:0].

Behaviour:
- One clock domain. `reset` is asynchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - `ready` = 0.
  - `hash` = 0.
  - Round counter, working registers a..h and the W window are all 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE + start=1, at the edge:
  - latch data[511:0] into a 16x32 W shift window;
  - load a..h with the IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19;
  - set round = 0; go to ROUND.
- ROUND, each cycle:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[round] + W[round]; T2 = Σ0(a) + Maj(a,b,c).
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2. All additions mod 2^32.
  - W[t] for t ≥ 16 is σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed on the fly as the window shifts by one word per round.
  - round increments; after round 63 go to DONE.
- Entering DONE, same edge as round 63:
  - `hash` ← {IV0+a, …, IV7+h}, using the post-round-63 values, each add mod 2^32;
  - `ready` ← 1.
- Latency: start sampled at edge N → `ready` and `hash` valid after edge N+64. That is 64 cycles; `ready` is visible from edge N+64 onward.
- DONE:
  - `ready` and `hash` hold indefinitely.
  - start=1 accepts a new block exactly as in IDLE; `ready` drops to 0 on that edge and `hash` keeps its old value until the next completion.
- start=1 during ROUND is ignored; the computation in progress is not disturbed.
- `data` is only sampled at the accepting edge and may change afterwards.
- Reset asserted mid-computation aborts immediately to the reset state; no partial `hash` is published.
- Reset and start on the same edge: reset wins.
- Standard functions (ROTR = rotate right, SHR = shift right):
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25;
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10;
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).

Test Plan:
- Reset check: hold reset → ready=0, hash=0; then assert reset asynchronously between clock edges mid-ROUND → ready=0 and hash=0 immediately, with no further updates.
- "abc" vector: data low 512 bits = 61626380 followed by zeros, final word 00000018; upper 128 bits = 0. Pulse start → ready rises exactly 64 cycles later, hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty-message vector: data[511:480] = 80000000, remainder 0 → hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Reserved bits: repeat "abc" with data[639:512] all ones → same digest as the "abc" vector.
- start while busy: pulse start again at round 30 with the empty-message block → the "abc" digest is still produced at cycle 64 and the second request is ignored.
- Back-to-back: while in DONE after "abc", pulse start with the empty block → ready falls on the next edge and hash holds the "abc" digest. Then 64 cycles later ready=1 and hash = e3b0c442…b855.
